// File: rtl/vector_pos_serializer.sv
// vector_pos_serializer: streams the position of every set bit of an accepted vector, lowest first.
// Ports:
//   clk        - single rising-edge clock
//   rst_n      - synchronous active-low reset
//   in_valid   - in_vec is valid
//   in_ready   - a vector can be accepted this cycle
//   in_vec     - vector to serialize, sampled only at accept
//   out_valid  - output beat is valid
//   out_ready  - consumer accepts the beat
//   out_idx    - binary position of the current set bit
//   out_onehot - one-hot mask of the current set bit
//   out_last   - final beat of the current vector
//   out_empty  - accepted vector was all-zero (single marker beat)
module vector_pos_serializer #(
    parameter int VECTOR_WIDTH = 16,
    localparam int IDX_W = $clog2(VECTOR_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [VECTOR_WIDTH-1:0] in_vec,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        out_idx,
    output logic [VECTOR_WIDTH-1:0] out_onehot,
    output logic                    out_last,
    output logic                    out_empty
);
    typedef enum logic [1:0] {IDLE, BUSY, EMPTY} state_t;
    localparam logic [VECTOR_WIDTH-1:0] ONE = VECTOR_WIDTH'(1);
    state_t                  r_state, w_state_nxt;
    logic [VECTOR_WIDTH-1:0] r_rem, w_rem_nxt;
    logic [VECTOR_WIDTH-1:0] w_low, w_rest;
    logic [IDX_W-1:0]        w_low_idx;
    logic                    w_fire, w_accept;
    // Two's-complement tricks: isolate and strip the lowest set bit, modulo 2^VECTOR_WIDTH.
    assign w_low  = r_rem & (~r_rem + ONE);
    assign w_rest = r_rem & (r_rem - ONE);
    always_comb begin
        w_low_idx = '0;
        for (int i = 0; i < VECTOR_WIDTH; i++)
            if (w_low[i]) w_low_idx = w_low_idx | IDX_W'(i);
    end
    assign w_fire   = out_valid && out_ready;
    assign in_ready = rst_n && (r_state == IDLE || (w_fire && out_last));
    assign w_accept = in_valid && in_ready;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end
    // Accept is only possible when idle or while the last beat drains, so it overrides everything.
    always_comb begin
        w_state_nxt = w_accept ? ((|in_vec) ? BUSY : EMPTY) :
                      (w_fire && out_last) ? IDLE : r_state;
        w_rem_nxt   = w_accept ? in_vec :
                      (w_fire && r_state == BUSY) ? w_rest : r_rem;
    end
    // Outputs are forced low while reset is asserted, even before the state register clears.
    always_comb begin
        out_valid  = rst_n && r_state != IDLE;
        out_idx    = (rst_n && r_state == BUSY) ? w_low_idx : '0;
        out_onehot = (rst_n && r_state == BUSY) ? w_low : '0;
        out_last   = rst_n && (r_state == EMPTY || (r_state == BUSY && w_rest == '0));
        out_empty  = rst_n && r_state == EMPTY;
    end
endmodule

// File: tb/tb_vector_pos_serializer.sv
// tb_vector_pos_serializer: randomized and directed checks against a beat-queue reference model.
module tb_vector_pos_serializer;
    typedef struct {
        logic [3:0]  idx;
        logic [15:0] oh;
        logic        last;
        logic        empty;
    } beat_t;
    logic        clk = 0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_last, out_empty;
    logic [15:0] in_vec, out_onehot;
    logic [3:0]  out_idx;
    beat_t       q[$];
    int          n_checks = 0, n_pass = 0, n_fail = 0;
    logic        stall_prev = 0;
    logic [3:0]  idx_prev;
    logic [15:0] oh_prev;
    logic        last_prev, empty_prev;
    always #5 clk = ~clk;
    vector_pos_serializer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_onehot(out_onehot), .out_last(out_last), .out_empty(out_empty)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // Reference: one queue entry per expected beat, derived directly from the vector's set bits.
    task automatic push_vec(input logic [15:0] v);
        beat_t b;
        int n, k;
        n = $countones(v);
        k = 0;
        if (v == 0) begin
            b.idx = 0; b.oh = 0; b.last = 1; b.empty = 1;
            q.push_back(b);
        end else
            for (int i = 0; i < 16; i++)
                if (v[i]) begin
                    k++;
                    b.idx = 4'(i); b.oh = 16'(1) << i; b.last = (k == n); b.empty = 0;
                    q.push_back(b);
                end
    endtask
    task automatic step(input logic rn, input logic iv, input logic [15:0] vec, input logic ordy);
        beat_t e;
        logic  ev, eir;
        rst_n = rn; in_valid = iv; in_vec = vec; out_ready = ordy;
        #1;
        ev = rn && q.size() > 0;
        e.idx = 0; e.oh = 0; e.last = 0; e.empty = 0;
        if (ev) e = q[0];
        eir = rn && (q.size() == 0 || (q[0].last && ordy));
        check("out_valid", 32'(out_valid), 32'(ev));
        check("in_ready", 32'(in_ready), 32'(eir));
        check("out_idx", 32'(out_idx), 32'(e.idx));
        check("out_onehot", 32'(out_onehot), 32'(e.oh));
        check("onehot_vs_idx", 32'(out_onehot), ev && !e.empty ? 32'(1) << out_idx : 32'(0));
        if (ev) begin
            check("out_last", 32'(out_last), 32'(e.last));
            check("out_empty", 32'(out_empty), 32'(e.empty));
        end else begin
            check("idle_last", 32'(out_last), 0);
            check("idle_empty", 32'(out_empty), 0);
        end
        if (stall_prev && rn) begin
            check("stall_idx", 32'(out_idx), 32'(idx_prev));
            check("stall_onehot", 32'(out_onehot), 32'(oh_prev));
            check("stall_last", 32'(out_last), 32'(last_prev));
            check("stall_empty", 32'(out_empty), 32'(empty_prev));
        end
        stall_prev = rn && out_valid && !ordy;
        idx_prev = out_idx; oh_prev = out_onehot; last_prev = out_last; empty_prev = out_empty;
        @(posedge clk);
        if (!rn) q.delete();
        else begin
            if (ev && ordy) void'(q.pop_front());
            if (iv && eir) push_vec(vec);
        end
        @(negedge clk);
    endtask
    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) step(1, 0, 16'h0, 1);
        check("drained", 32'(q.size()), 0);
        step(1, 0, 16'h0, 1);
    endtask
    initial begin
        logic [15:0] v;
        @(negedge clk);
        step(0, 0, 16'h0, 0);
        step(0, 1, 16'hFFFF, 1);
        step(1, 1, 16'h8421, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 16'h0, 1);
        step(1, 1, 16'h0000, 1);
        drain();
        step(1, 1, 16'hFFFF, 1);
        for (int i = 0; i < 48 && q.size() > 0; i++) step(1, 0, 16'h1234, (i % 3) == 0);
        drain();
        step(1, 1, 16'h0003, 1);
        step(1, 1, 16'h0000, 1);
        step(1, 1, 16'h8000, 1);
        step(1, 1, 16'h8000, 1);
        step(1, 0, 16'h0, 1);
        drain();
        step(1, 1, 16'h00FF, 1);
        step(1, 0, 16'h0, 1);
        step(1, 0, 16'h0, 1);
        step(0, 0, 16'h0, 1);
        step(0, 0, 16'h0, 1);
        step(1, 0, 16'h0, 1);
        step(1, 1, 16'h0010, 1);
        drain();
        for (int c = 0; c < 25000; c++) begin
            case ($urandom_range(7))
                0: v = 16'h0000;
                1: v = 16'hFFFF;
                2: v = 16'(1) << $urandom_range(15);
                default: v = 16'($urandom);
            endcase
            step($urandom_range(999) != 0, $urandom_range(3) != 0, v, $urandom_range(3) != 0);
        end
        drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
